// File: rtl/axi_data_slave_mem.sv
// AXI4 slave memory: one transaction at a time, FIXED/INCR bursts, sticky per-burst
// write response and per-beat read response, backed by an internal word array.
module axi_data_slave_mem #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_USER_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXI_ID_WIDTH-1:0]     awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic [AXI_USER_WIDTH-1:0]   awuser,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        wlast,
  input  logic [AXI_USER_WIDTH-1:0]   wuser,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [AXI_ID_WIDTH-1:0]     bid,
  output logic [1:0]                  bresp,
  output logic [AXI_USER_WIDTH-1:0]   buser,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [AXI_ID_WIDTH-1:0]     arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic [AXI_USER_WIDTH-1:0]   aruser,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [AXI_ID_WIDTH-1:0]     rid,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic [AXI_USER_WIDTH-1:0]   ruser,
  output logic                        rvalid,
  input  logic                        rready
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // DECERR dominates SLVERR, which dominates OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
      return RESP_DECERR;
    end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
      return RESP_SLVERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  function automatic logic [AXI_ADDR_WIDTH-1:0] addr_step(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
    if (burst == 2'b01) begin
      return addr + (AXI_ADDR_WIDTH'(1) << size);
    end else begin
      return addr;
    end
  endfunction

  function automatic logic addr_decerr(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr >> OFF_W) >= AXI_ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  state_t                      state_r, state_nxt_s;
  logic                        prio_w_r;
  logic                        grant_w_s, grant_r_s;
  logic [AXI_ADDR_WIDTH-1:0]   addr_r, next_addr_s, rd_addr_s;
  logic [7:0]                  len_r, cnt_r;
  logic [2:0]                  size_r;
  logic [1:0]                  burst_r;
  logic [AXI_ID_WIDTH-1:0]     bid_r, rid_r;
  logic [AXI_USER_WIDTH-1:0]   buser_r, ruser_r;
  logic [1:0]                  bresp_r, rresp_r, rd_resp_s, wr_resp_s;
  logic [AXI_DATA_WIDTH-1:0]   rdata_r, rd_word_s;
  logic                        rlast_r, rd_bad_s, rd_dec_s, wr_dec_s, mem_we_s, beat_last_s;
  logic                        aw_hs_s, ar_hs_s, w_hs_s, b_hs_s, r_hs_s;
  logic [AXI_DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  assign grant_w_s   = awvalid & (~arvalid | prio_w_r);
  assign grant_r_s   = arvalid & ~grant_w_s;
  assign aw_hs_s     = awvalid & awready;
  assign ar_hs_s     = arvalid & arready;
  assign w_hs_s      = wvalid & wready;
  assign b_hs_s      = bvalid & bready;
  assign r_hs_s      = rvalid & rready;
  assign beat_last_s = (cnt_r == len_r);
  assign next_addr_s = addr_step(addr_r, size_r, burst_r);

  // Write-beat decode: WRAP/reserved and out-of-range beats never touch the array.
  always_comb begin
    wr_dec_s  = addr_decerr(addr_r);
    mem_we_s  = w_hs_s & ~wr_dec_s & ~burst_r[1];
    wr_resp_s = resp_merge(burst_r[1] ? RESP_SLVERR : RESP_OKAY,
                           wr_dec_s ? RESP_DECERR : RESP_OKAY);
    if (wlast != beat_last_s) begin
      wr_resp_s = resp_merge(wr_resp_s, RESP_SLVERR);
    end else begin
      wr_resp_s = wr_resp_s;
    end
  end

  // Read fetch: first beat comes from the AR channel, later beats from the stepped address.
  always_comb begin
    if (state_r == ST_IDLE) begin
      rd_addr_s = araddr;
      rd_bad_s  = arburst[1];
    end else begin
      rd_addr_s = next_addr_s;
      rd_bad_s  = burst_r[1];
    end
    rd_dec_s  = addr_decerr(rd_addr_s);
    rd_resp_s = resp_merge(rd_bad_s ? RESP_SLVERR : RESP_OKAY,
                           rd_dec_s ? RESP_DECERR : RESP_OKAY);
    if (rd_bad_s || rd_dec_s) begin
      rd_word_s = {AXI_DATA_WIDTH{1'b0}};
    end else begin
      rd_word_s = mem_r[rd_addr_s[OFF_W +: IDX_W]];
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (aw_hs_s) begin
          state_nxt_s = ST_WRITE;
        end else if (ar_hs_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (w_hs_s && beat_last_s) begin
          state_nxt_s = ST_WRESP;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_WRESP: begin
        if (b_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRESP;
        end
      end
      ST_READ: begin
        if (r_hs_s && rlast_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        awready = grant_w_s;
        arready = grant_r_s;
      end
      ST_WRITE: wready = 1'b1;
      ST_WRESP: bvalid = 1'b1;
      ST_READ:  rvalid = 1'b1;
      default:  awready = 1'b0;
    endcase
  end

  // Round-robin priority flips only when both address channels compete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_w_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && awvalid && arvalid) begin
      prio_w_r <= ~prio_w_r;
    end else begin
      prio_w_r <= prio_w_r;
    end
  end

  // Burst context, beat counter and registered B/R outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
      len_r   <= 8'd0;
      cnt_r   <= 8'd0;
      size_r  <= 3'd0;
      burst_r <= 2'b00;
      bid_r   <= {AXI_ID_WIDTH{1'b0}};
      buser_r <= {AXI_USER_WIDTH{1'b0}};
      bresp_r <= RESP_OKAY;
      rid_r   <= {AXI_ID_WIDTH{1'b0}};
      ruser_r <= {AXI_USER_WIDTH{1'b0}};
      rdata_r <= {AXI_DATA_WIDTH{1'b0}};
      rresp_r <= RESP_OKAY;
      rlast_r <= 1'b0;
    end else if (aw_hs_s) begin
      addr_r  <= awaddr;
      len_r   <= awlen;
      cnt_r   <= 8'd0;
      size_r  <= awsize;
      burst_r <= awburst;
      bid_r   <= awid;
      buser_r <= awuser;
      bresp_r <= RESP_OKAY;
    end else if (ar_hs_s) begin
      addr_r  <= araddr;
      len_r   <= arlen;
      cnt_r   <= 8'd0;
      size_r  <= arsize;
      burst_r <= arburst;
      rid_r   <= arid;
      ruser_r <= aruser;
      rdata_r <= rd_word_s;
      rresp_r <= rd_resp_s;
      rlast_r <= (arlen == 8'd0);
    end else if (w_hs_s) begin
      addr_r  <= next_addr_s;
      cnt_r   <= cnt_r + 8'd1;
      bresp_r <= resp_merge(bresp_r, wr_resp_s);
    end else if (r_hs_s && !rlast_r) begin
      addr_r  <= next_addr_s;
      cnt_r   <= cnt_r + 8'd1;
      rdata_r <= rd_word_s;
      rresp_r <= rd_resp_s;
      rlast_r <= ((cnt_r + 8'd1) == len_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Byte-enabled array write; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem_r[addr_r[OFF_W +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign bid   = bid_r;
  assign bresp = bresp_r;
  assign buser = buser_r;
  assign rid   = rid_r;
  assign rdata = rdata_r;
  assign rresp = rresp_r;
  assign rlast = rlast_r;
  assign ruser = ruser_r;

endmodule

// File: tb/tb_axi_data_slave_mem.sv
// Scoreboard bench for axi_data_slave_mem: expected read beats are queued as stimulus is
// issued and compared against collected R beats.
module tb_axi_data_slave_mem;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  awid = 8'd0, arid = 8'd0, bid, rid;
  logic [31:0] awaddr = 32'd0, araddr = 32'd0, awuser = 32'd0, aruser = 32'd0;
  logic [7:0]  awlen = 8'd0, arlen = 8'd0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        bready = 1'b0, rready = 1'b0;
  logic        awready, arready, wready, bvalid, rvalid, rlast;
  logic [31:0] wdata = 32'd0, wuser = 32'd0, rdata, buser, ruser;
  logic [3:0]  wstrb = 4'hF;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [31:0] wq[$];
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  int          stall_diff = 0;
  logic [1:0]  resp_v;
  logic [7:0]  bid_v;

  axi_data_slave_mem dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic timeout_fail(input string what);
    total++;
    bad++;
    $display("FAIL timeout_%s: handshake not seen, required within bound", what);
  endtask

  // Drives one write burst from wq; AW may already have been handshaken by the caller.
  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int last_beat,
                          input bit skip_aw, output logic [1:0] resp, output logic [7:0] bid_o);
    int n;
    resp = 2'bxx;
    bid_o = 8'hxx;
    if (!skip_aw) begin
      @(negedge clk_i);
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst;
      awuser = 32'hA000_0000 | 32'(id); awvalid = 1'b1;
      #1;
      n = 0;
      while (!awready && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!awready) begin awvalid = 1'b0; timeout_fail("aw"); return; end
      @(negedge clk_i);
      awvalid = 1'b0;
    end
    for (int i = 0; i <= int'(len); i++) begin
      wdata = (wq.size() > 0) ? wq.pop_front() : 32'd0;
      wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
      #1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!wready) begin wvalid = 1'b0; timeout_fail("w"); return; end
      @(negedge clk_i);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk_i); #1; n++; end
    if (!bvalid) begin bready = 1'b0; timeout_fail("b"); return; end
    resp = bresp;
    bid_o = bid;
    @(negedge clk_i);
    bready = 1'b0;
  endtask

  // Issues one read burst and records every R handshake; stall toggles rready 1/0.
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit stall, input bit skip_ar);
    int   n;
    bit   phase, held, done;
    beat_t hv, cur;
    if (!skip_ar) begin
      @(negedge clk_i);
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
      aruser = 32'hB000_0000 | 32'(id); arvalid = 1'b1;
      #1;
      n = 0;
      while (!arready && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!arready) begin arvalid = 1'b0; timeout_fail("ar"); return; end
      @(negedge clk_i);
      arvalid = 1'b0;
    end
    phase = 1'b1; held = 1'b0; done = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      rready = stall ? phase : 1'b1;
      #1;
      cur = '{data: rdata, resp: rresp, last: rlast, id: rid};
      if (held) begin
        if (cur !== hv) stall_diff++;
        held = 1'b0;
      end
      if (rvalid && rready) begin
        obs_q.push_back(cur);
        if (rlast) done = 1'b1;
      end else if (rvalid) begin
        hv = cur; held = 1'b1; stall_cnt++;
      end
      phase = !phase;
      @(negedge clk_i);
    end
    rready = 1'b0;
    if (!done) timeout_fail("r");
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [7:0] id);
    exp_q.push_back('{data: d, resp: r, last: l, id: id});
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got %b required 000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    total++;
    if ({bresp, rresp} !== 4'b0) begin
      bad++; $display("FAIL reset_resp got bresp=%0d rresp=%0d required 0 0", bresp, rresp);
    end
    total++;
    if (rdata !== 32'd0 || ruser !== 32'd0 || buser !== 32'd0) begin
      bad++; $display("FAIL reset_data got rdata=%h ruser=%h buser=%h required 0", rdata, ruser, buser);
    end
    total++;
    if ({bid, rid} !== 16'd0) begin
      bad++; $display("FAIL reset_ids got bid=%h rid=%h required 0 0", bid, rid);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_arbitration();
    beat_t e, o;
    @(negedge clk_i);
    awid = 8'h07; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 8'h21; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    total++;
    if ({awready, arready} !== 2'b10) begin
      bad++; $display("FAIL arb_first got aw/ar ready=%b required 10", {awready, arready});
    end
    @(negedge clk_i);
    awvalid = 1'b0; arvalid = 1'b0;
    wq.push_back(32'h1234_5678);
    do_write(8'h07, 32'h40, 8'd0, 2'b01, 4'hF, 0, 1'b1, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b00 || bid_v !== 8'h07) begin
      bad++; $display("FAIL arb_bresp got resp=%0d bid=%h required 0 07", resp_v, bid_v);
    end
    @(negedge clk_i);
    awaddr = 32'h44; awvalid = 1'b1; arvalid = 1'b1;
    #1;
    total++;
    if ({awready, arready} !== 2'b01) begin
      bad++; $display("FAIL arb_second got aw/ar ready=%b required 01", {awready, arready});
    end
    @(negedge clk_i);
    awvalid = 1'b0; arvalid = 1'b0;
    push_exp(32'h1234_5678, 2'b00, 1'b1, 8'h21);
    do_read(8'h21, 32'h40, 8'd0, 2'b01, 1'b0, 1'b1);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL arb_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL arb_rbeat got %h/%0d/%0b/%h required %h/%0d/%0b/%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single();
    beat_t e, o;
    wq.push_back(32'hDEAD_BEEF);
    do_write(8'h05, 32'h10, 8'd0, 2'b01, 4'hF, 0, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b00 || bid_v !== 8'h05) begin
      bad++; $display("FAIL single_b got resp=%0d bid=%h required 0 05", resp_v, bid_v);
    end
    push_exp(32'hDEAD_BEEF, 2'b00, 1'b1, 8'h3C);
    do_read(8'h3C, 32'h10, 8'd0, 2'b01, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL single_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL single_rbeat got %h/%0d/%0b/%h required %h/%0d/%0b/%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_incr_backpressure();
    beat_t e, o;
    for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
    do_write(8'h11, 32'h100, 8'd3, 2'b01, 4'hF, 3, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b00) begin
      bad++; $display("FAIL incr_b got resp=%0d required 0", resp_v);
    end
    for (int i = 1; i <= 4; i++) push_exp(32'(i), 2'b00, (i == 4), 8'h44);
    stall_cnt = 0; stall_diff = 0;
    do_read(8'h44, 32'h100, 8'd3, 2'b01, 1'b1, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL incr_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL incr_rbeat got %h/%0d/%0b/%h required %h/%0d/%0b/%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
    total++;
    if (stall_cnt == 0 || stall_diff != 0) begin
      bad++; $display("FAIL incr_stall got stalls=%0d changes=%0d required >0 and 0", stall_cnt, stall_diff);
    end
  endtask

  task automatic test_strobes();
    beat_t e, o;
    wq.push_back(32'hFFFF_FFFF);
    do_write(8'h02, 32'h20, 8'd0, 2'b01, 4'hF, 0, 1'b0, resp_v, bid_v);
    wq.push_back(32'h0000_0000);
    do_write(8'h03, 32'h20, 8'd0, 2'b01, 4'h5, 0, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b00 || bid_v !== 8'h03) begin
      bad++; $display("FAIL strb_b got resp=%0d bid=%h required 0 03", resp_v, bid_v);
    end
    push_exp(32'hFF00_FF00, 2'b00, 1'b1, 8'h55);
    do_read(8'h55, 32'h20, 8'd0, 2'b01, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL strb_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL strb_rbeat got %h/%0d/%0b/%h required %h/%0d/%0b/%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_errors();
    beat_t e, o;
    wq.push_back(32'h0BAD_F00D);
    do_write(8'h01, 32'h0, 8'd0, 2'b01, 4'hF, 0, 1'b0, resp_v, bid_v);
    wq.push_back(32'hA5A5_A5A5);
    do_write(8'h01, 32'h300, 8'd0, 2'b01, 4'hF, 0, 1'b0, resp_v, bid_v);
    wq.push_back(32'h1111_1111); wq.push_back(32'h2222_2222);
    do_write(8'h01, 32'h200, 8'd1, 2'b01, 4'hF, 1, 1'b0, resp_v, bid_v);
    wq.push_back(32'hFFFF_FFFF);
    do_write(8'h61, 32'h1000, 8'd0, 2'b01, 4'hF, 0, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b11) begin
      bad++; $display("FAIL err_decerr got resp=%0d required 3", resp_v);
    end
    wq.push_back(32'h0000_0000);
    do_write(8'h62, 32'h300, 8'd0, 2'b10, 4'hF, 0, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b10 || bid_v !== 8'h62) begin
      bad++; $display("FAIL err_wrap got resp=%0d bid=%h required 2 62", resp_v, bid_v);
    end
    wq.push_back(32'h1111_1111); wq.push_back(32'h2222_2222);
    do_write(8'h63, 32'h200, 8'd1, 2'b01, 4'hF, 0, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b10) begin
      bad++; $display("FAIL err_wlast got resp=%0d required 2", resp_v);
    end
    push_exp(32'h0BAD_F00D, 2'b00, 1'b1, 8'h70);
    do_read(8'h70, 32'h0, 8'd0, 2'b01, 1'b0, 1'b0);
    push_exp(32'h0, 2'b11, 1'b1, 8'h71);
    do_read(8'h71, 32'h1000, 8'd0, 2'b01, 1'b0, 1'b0);
    push_exp(32'hA5A5_A5A5, 2'b00, 1'b1, 8'h72);
    do_read(8'h72, 32'h300, 8'd0, 2'b01, 1'b0, 1'b0);
    push_exp(32'h1111_1111, 2'b00, 1'b0, 8'h73);
    push_exp(32'h2222_2222, 2'b00, 1'b1, 8'h73);
    do_read(8'h73, 32'h200, 8'd1, 2'b01, 1'b0, 1'b0);
    push_exp(32'h0, 2'b10, 1'b0, 8'h74);
    push_exp(32'h0, 2'b10, 1'b1, 8'h74);
    do_read(8'h74, 32'h300, 8'd1, 2'b10, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL err_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL err_rbeat got %h/%0d/%0b/%h required %h/%0d/%0b/%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_long_burst();
    beat_t e, o;
    int    errs;
    for (int i = 0; i < 256; i++) wq.push_back(32'h5A00_0000 + 32'(i));
    do_write(8'h80, 32'h400, 8'd255, 2'b01, 4'hF, 255, 1'b0, resp_v, bid_v);
    total++;
    if (resp_v !== 2'b00 || bid_v !== 8'h80) begin
      bad++; $display("FAIL long_b got resp=%0d bid=%h required 0 80", resp_v, bid_v);
    end
    for (int i = 0; i < 256; i++) push_exp(32'h5A00_0000 + 32'(i), 2'b00, (i == 255), 8'h81);
    do_read(8'h81, 32'h400, 8'd255, 2'b01, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL long_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    errs = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; errs++;
        if (errs <= 4) $display("FAIL long_rbeat got %h/%0d/%0b required %h/%0d/%0b", o.data, o.resp, o.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    beat_t e, o;
    int    n;
    @(negedge clk_i);
    arid = 8'h90; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk_i); #1; n++; end
    if (!arready) begin arvalid = 1'b0; timeout_fail("ar_mid"); return; end
    @(negedge clk_i);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk_i);
    #1;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'd2) begin
      bad++; $display("FAIL mid_beat2 got rvalid=%b rdata=%h required 1 00000002", rvalid, rdata);
    end
    rst_i = 1'b1;
    #1;
    total++;
    if (rvalid !== 1'b0 || rdata !== 32'd0 || rid !== 8'd0) begin
      bad++; $display("FAIL mid_reset got rvalid=%b rdata=%h rid=%h required 0 0 0", rvalid, rdata, rid);
    end
    rready = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    push_exp(32'd1, 2'b00, 1'b1, 8'h91);
    push_exp(32'hDEAD_BEEF, 2'b00, 1'b1, 8'h92);
    do_read(8'h91, 32'h100, 8'd0, 2'b01, 1'b0, 1'b0);
    do_read(8'h92, 32'h10, 8'd0, 2'b01, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL mid_rcount got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL mid_rbeat got %h/%0d/%0b/%h required %h/%0d/%0b/%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single();
    test_incr_backpressure();
    test_strobes();
    test_errors();
    test_long_burst();
    test_reset_mid_burst();
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
